// File: rtl/alu_wide_seq.sv
// Multi-byte sequencer that drives an 8-bit combinational ALU one byte per cycle,
// chaining carry/shift between bytes. Optional ZERO_ALL accumulation: ALU_SEQ_ZERO_EN.
module alu_wide_seq #(
  parameter int unsigned MAX_BYTES = 4,
  localparam int unsigned LW = $clog2(MAX_BYTES + 1),
  localparam int unsigned DW = 8 * MAX_BYTES
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          START,
  input  logic [2:0]    OP,
  input  logic [LW-1:0] LEN,
  input  logic [DW-1:0] A_IN,
  input  logic [DW-1:0] B_IN,
  output logic [7:0]    ALU_A,
  output logic [7:0]    ALU_B,
  output logic [2:0]    ALU_OP,
  output logic          ALU_C_IN,
  output logic          ALU_S_IN,
  input  logic [7:0]    ALU_OUT,
  input  logic          ALU_C_OUT,
  input  logic          ALU_S_OUT,
  input  logic          ALU_ZERO,
  output logic [DW-1:0] RESULT,
  output logic          C_FINAL,
  output logic          ZERO_ALL,
  output logic          BUSY,
  output logic          DONE
);

  localparam int unsigned IW = $clog2(MAX_BYTES);

  localparam logic [2:0] K_ADD  = 3'd0;
  localparam logic [2:0] K_SUB  = 3'd1;
  localparam logic [2:0] K_SHL  = 3'd2;
  localparam logic [2:0] K_SHR  = 3'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [2:0]    op_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] cnt;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic          chain;

  logic [LW-1:0] len_norm;
  logic [IW-1:0] idx;
  logic [7:0]    a_byte;
  logic [7:0]    b_byte;
  logic          accept;
  logic          first;
  logic          last;
  logic          chain_nxt;

  // Out-of-range lengths (0 or above MAX_BYTES) run at full width.
  always_comb begin
    len_norm = LEN;
    if (LEN == '0 || LEN > LW'(MAX_BYTES)) begin
      len_norm = LW'(MAX_BYTES);
    end
  end

  assign accept = START && (state == S_IDLE || state == S_DONE);
  assign first  = (cnt == '0);
  assign last   = (cnt == len_q - LW'(1));

  // Right shifts walk from the top byte down so the shifted-out bit flows toward the LSB.
  assign idx = (op_q == K_SHR) ? IW'(len_q - cnt - LW'(1)) : IW'(cnt);

  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < int'(MAX_BYTES); i++) begin
      if (idx == IW'(i)) begin
        a_byte = a_q[8*i +: 8];
        b_byte = b_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = S_RUN;
      S_RUN:   if (last) state_nxt = S_DONE;
      S_DONE:  state_nxt = START ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Byte issue; subtraction goes through the adder as A + ~B + 1 to keep the carry.
  always_comb begin
    ALU_A    = '0;
    ALU_B    = '0;
    ALU_OP   = K_ADD;
    ALU_C_IN = 1'b0;
    ALU_S_IN = 1'b0;
    if (state == S_RUN) begin
      ALU_A = a_byte;
      case (op_q)
        K_ADD: begin
          ALU_B    = b_byte;
          ALU_C_IN = first ? 1'b0 : chain;
        end
        K_SUB: begin
          ALU_B    = ~b_byte;
          ALU_C_IN = first ? 1'b1 : chain;
        end
        K_SHL, K_SHR: begin
          ALU_OP   = op_q;
          ALU_B    = 8'd1;
          ALU_S_IN = first ? 1'b0 : chain;
        end
        default: begin
          ALU_OP = op_q;
          ALU_B  = b_byte;
        end
      endcase
    end
  end

  always_comb begin
    chain_nxt = 1'b0;
    case (op_q)
      K_ADD, K_SUB: chain_nxt = ALU_C_OUT;
      K_SHL, K_SHR: chain_nxt = ALU_S_OUT;
      default:      chain_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_q    <= K_ADD;
      len_q   <= '0;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      chain   <= 1'b0;
      RESULT  <= '0;
      C_FINAL <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
    end else begin
      BUSY <= (state_nxt == S_RUN);
      DONE <= (state_nxt == S_DONE);
      if (accept) begin
        op_q    <= OP;
        len_q   <= len_norm;
        a_q     <= A_IN;
        b_q     <= B_IN;
        cnt     <= '0;
        chain   <= 1'b0;
        RESULT  <= '0;
        C_FINAL <= 1'b0;
      end else if (state == S_RUN) begin
        for (int i = 0; i < int'(MAX_BYTES); i++) begin
          if (idx == IW'(i)) begin
            RESULT[8*i +: 8] <= ALU_OUT;
          end
        end
        chain <= chain_nxt;
        cnt   <= cnt + LW'(1);
        if (last) begin
          C_FINAL <= chain_nxt;
        end
      end
    end
  end

`ifdef ALU_SEQ_ZERO_EN
  logic zero_acc;
  logic zero_all_q;

  // Running AND of per-byte zero flags, published on the last byte.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      zero_acc   <= 1'b0;
      zero_all_q <= 1'b0;
    end else if (accept) begin
      zero_acc   <= 1'b1;
      zero_all_q <= 1'b0;
    end else if (state == S_RUN) begin
      zero_acc <= zero_acc & ALU_ZERO;
      if (last) begin
        zero_all_q <= zero_acc & ALU_ZERO;
      end
    end
  end

  assign ZERO_ALL = zero_all_q;
`else
  logic unused_zero;
  assign unused_zero = ALU_ZERO;
  assign ZERO_ALL    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_wide_seq.sv
// Self-checking bench for alu_wide_seq with a behavioural 8-bit ALU and a wide-word reference model.
module tb_alu_wide_seq;

  localparam logic [2:0] K_ADD  = 3'd0;
  localparam logic [2:0] K_SUB  = 3'd1;
  localparam logic [2:0] K_SHL  = 3'd2;
  localparam logic [2:0] K_SHR  = 3'd3;
  localparam logic [2:0] K_XOR  = 3'd4;
  localparam logic [2:0] K_AND  = 3'd5;
  localparam logic [2:0] K_OR   = 3'd6;
  localparam logic [2:0] K_PASS = 3'd7;

`ifdef ALU_SEQ_ZERO_EN
  localparam bit ZEN = 1'b1;
`else
  localparam bit ZEN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [2:0]  len;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_c_in;
  logic        alu_s_in;
  logic [7:0]  alu_out;
  logic        alu_c_out;
  logic        alu_s_out;
  logic        alu_zero;
  logic [31:0] result;
  logic        c_final;
  logic        zero_all;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  alu_wide_seq #(.MAX_BYTES(4)) dut (
    .CLK(clk), .RESET(rst), .START(start), .OP(op), .LEN(len),
    .A_IN(a_in), .B_IN(b_in),
    .ALU_A(alu_a), .ALU_B(alu_b), .ALU_OP(alu_op), .ALU_C_IN(alu_c_in), .ALU_S_IN(alu_s_in),
    .ALU_OUT(alu_out), .ALU_C_OUT(alu_c_out), .ALU_S_OUT(alu_s_out), .ALU_ZERO(alu_zero),
    .RESULT(result), .C_FINAL(c_final), .ZERO_ALL(zero_all), .BUSY(busy), .DONE(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 8-bit combinational ALU the sequencer is meant to drive.
  always_comb begin
    alu_out   = '0;
    alu_c_out = 1'b0;
    alu_s_out = 1'b0;
    case (alu_op)
      K_ADD:  {alu_c_out, alu_out} = 9'(alu_a) + 9'(alu_b) + 9'(alu_c_in);
      K_SUB:  alu_out = alu_a - alu_b;
      K_SHL:  begin alu_out = {alu_a[6:0], alu_s_in}; alu_s_out = alu_a[7]; end
      K_SHR:  begin alu_out = {alu_s_in, alu_a[7:1]}; alu_s_out = alu_a[0]; end
      K_XOR:  alu_out = alu_a ^ alu_b;
      K_AND:  alu_out = alu_a & alu_b;
      K_OR:   alu_out = alu_a | alu_b;
      default: alu_out = alu_a;
    endcase
    alu_zero = (alu_out == 8'd0);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  function automatic int eff_len(input logic [2:0] l);
    return (l == 3'd0 || l > 3'd4) ? 4 : int'(l);
  endfunction

  // Whole-word reference: {zero, carry, result}.
  function automatic logic [33:0] ref_op(input logic [2:0] o, input logic [2:0] l,
                                         input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [63:0] m, aa, bb, s;
    logic [31:0] r;
    logic c;
    n  = eff_len(l);
    m  = (64'd1 << (8 * n)) - 64'd1;
    aa = {32'd0, a} & m;
    bb = {32'd0, b} & m;
    c  = 1'b0;
    case (o)
      K_ADD:  begin s = aa + bb; c = s[8*n]; end
      K_SUB:  begin s = aa + (~bb & m) + 64'd1; c = s[8*n]; end
      K_SHL:  begin s = aa << 1; c = aa[8*n-1]; end
      K_SHR:  begin s = aa >> 1; c = aa[0]; end
      K_XOR:  s = aa ^ bb;
      K_AND:  s = aa & bb;
      K_OR:   s = aa | bb;
      default: s = aa;
    endcase
    r = 32'(s & m);
    return {(r == 32'd0), c, r};
  endfunction

  // Transaction-level model: cycles remaining until DONE, and what RESULT should show.
  int          rem = 0;
  logic [33:0] pend = '0;
  logic [33:0] shown = '0;

  always @(posedge clk) begin
    if (rst) begin
      rem   <= 0;
      shown <= '0;
    end else if (start && rem <= 1) begin
      rem   <= eff_len(len) + 1;
      pend  <= ref_op(op, len, a_in, b_in);
      shown <= '0;
    end else if (rem > 0) begin
      rem <= rem - 1;
      if (rem == 2) shown <= pend;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_busy", 64'(busy), 64'(rem >= 2));
      check("mon_done", 64'(done), 64'(rem == 1));
      if (rem <= 1) begin
        check("mon_result", 64'(result), 64'(shown[31:0]));
        check("mon_cfinal", 64'(c_final), 64'(shown[32]));
        check("mon_zero", 64'(zero_all), 64'(ZEN & shown[33]));
      end
    end
  end

  // Issue one op at the current negedge and wait for DONE; optionally disturb inputs mid-run.
  task automatic do_op(input string name, input logic [2:0] o, input logic [2:0] l,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ec, input bit ez, input bit disturb);
    int  cycles;
    bit  seen;
    op = o; len = l; a_in = a; b_in = b; start = 1'b1;
    cycles = 0;
    seen = 1'b0;
    while (!seen && cycles < 20) begin
      @(negedge clk);
      cycles++;
      start = disturb && cycles == 1;
      if (cycles == 1) begin
        check({name, "_busy1"}, 64'(busy), 64'd1);
        if (disturb) begin
          op = K_PASS; len = 3'd1; a_in = ~a; b_in = 32'hA5A5_5A5A;
        end
      end
      if (done) seen = 1'b1;
    end
    check({name, "_seen"}, 64'(seen), 64'd1);
    check({name, "_cycles"}, 64'(cycles), 64'(eff_len(l) + 1));
    check({name, "_result"}, 64'(result), 64'(er));
    check({name, "_cfinal"}, 64'(c_final), 64'(ec));
    check({name, "_zero"}, 64'(zero_all), 64'(ZEN & ez));
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; op = K_ADD; len = 3'd0; a_in = '0; b_in = '0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({busy, done, c_final, zero_all}), 64'd0);
    check("rst_alu", 64'({alu_a, alu_b, alu_op, alu_c_in, alu_s_in}), 64'd0);
    check("model_sub", 64'(ref_op(K_SUB, 3'd4, 32'd5, 32'd3)), 64'({1'b0, 1'b1, 32'd2}));
    check("model_shr", 64'(ref_op(K_SHR, 3'd2, 32'h0101, 32'd0)), 64'({1'b0, 1'b1, 32'h80}));
    rst = 1'b0;
    @(negedge clk);

    do_op("add2",  K_ADD, 3'd2, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op("sub01", K_SUB, 3'd4, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op("sub53", K_SUB, 3'd4, 32'd5, 32'd3, 32'h0000_0002, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    do_op("shl3",  K_SHL, 3'd3, 32'h0080_0001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    do_op("shr2",  K_SHR, 3'd2, 32'hABCD_0101, 32'h0, 32'h0000_0080, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    do_op("and1",  K_AND, 3'd1, 32'hFFFF_FF0F, 32'hFFFF_FFF3, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op("xor4",  K_XOR, 3'd4, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    do_op("or_len0", K_OR, 3'd0, 32'h0100_0000, 32'h0000_0002, 32'h0100_0002, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    do_op("pass_len7", K_PASS, 3'd7, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    // Back-to-back: START issued while DONE is high.
    do_op("b2b_add", K_ADD, 3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b1, 1'b1, 1'b0);
    do_op("b2b_shl", K_SHL, 3'd4, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("idle_hold_result", 64'(result), 64'd0);
    check("idle_hold_busy", 64'(busy), 64'd0);

    // Reset on the second RUN cycle aborts without a DONE pulse.
    op = K_ADD; len = 3'd4; a_in = 32'h1111_1111; b_in = 32'h2222_2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", 64'(pulses), 64'd0);

    do_op("post_abort_sub", K_SUB, 3'd2, 32'h0000_1000, 32'h0000_0001, 32'h0000_0FFF, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
